// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared types and constants for the multiplier issue controller
package mult_ctrl_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
  typedef struct packed {
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;
endpackage

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: sequences both issue slots onto one iterative multiplier and owns HI/LO
module mult_issue_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = mult_ctrl_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  input  logic               req0_signed,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  input  logic               req1_signed,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic               mf_req,
  input  logic               mthi_we,
  input  logic               mtlo_we,
  input  logic [WIDTH-1:0]   mt_data,
  output logic               core_start,
  output logic               core_signed,
  output logic [WIDTH-1:0]   core_a,
  output logic [WIDTH-1:0]   core_b,
  input  logic               core_busy,
  input  logic               core_done,
  input  logic [2*WIDTH-1:0] core_product,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               stall
);
  state_t state, state_n;
  op_t    op_q;
  logic   pend;
  logic   any_req, launch, done, mt_ok;
  assign any_req = req0_valid | req1_valid;
  assign launch  = state == IDLE && any_req && !core_busy;
  assign done    = state == RUN && core_done;
  assign mt_ok   = (state == IDLE && !any_req) || done;
  // next state, start pulse, operand routing and stall
  always_comb begin
    state_n     = state;
    stall       = 1'b1;
    core_start  = 1'b0;
    core_signed = req0_valid ? req0_signed : req1_signed;
    core_a      = req0_valid ? req0_a : req1_a;
    core_b      = req0_valid ? req0_b : req1_b;
    unique case (state)
      IDLE: begin
        stall      = any_req;
        core_start = launch;
        state_n    = launch ? RUN : IDLE;
      end
      ISSUE: begin
        core_start  = 1'b1;
        core_signed = op_q.sgn;
        core_a      = op_q.a;
        core_b      = op_q.b;
        state_n     = RUN;
      end
      RUN: begin
        stall   = core_done ? (pend | mf_req) : 1'b1;
        state_n = core_done ? (pend ? ISSUE : IDLE) : RUN;
      end
      default: state_n = IDLE;
    endcase
    core_start = core_start & reset_n;
  end
  // state register and slot 1 operand latch for paired issue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pend  <= 1'b0;
      op_q  <= '0;
    end else begin
      state <= state_n;
      if (launch && req0_valid && req1_valid) begin
        pend <= 1'b1;
        op_q <= {req1_signed, req1_a, req1_b};
      end else if (done) begin
        pend <= 1'b0;
      end
    end
  end
  // HI/LO update: product on done, MT writes win since they are younger
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= (mt_ok && mthi_we) ? mt_data : done ? core_product[2*WIDTH-1:WIDTH] : hi;
      lo <= (mt_ok && mtlo_we) ? mt_data : done ? core_product[WIDTH-1:0] : lo;
    end
  end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: directed checks of the multiplier issue controller with a 65-cycle core model
module tb_mult_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req0_signed = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0;
  logic        req1_valid = 1'b0, req1_signed = 1'b0;
  logic [31:0] req1_a = '0, req1_b = '0;
  logic        mf_req = 1'b0, mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [31:0] mt_data = '0;
  logic        core_start, core_signed;
  logic [31:0] core_a, core_b;
  logic        core_busy = 1'b0;
  logic        core_done;
  logic [63:0] core_product = '0;
  logic [31:0] hi, lo;
  logic        stall;
  logic [6:0]  cnt = '0;
  logic        prev_start = 1'b0;
  int          compared = 0, mismatched = 0, starts = 0, rule_bad = 0;
  int          s0, n;

  always #5 clk = ~clk;

  mult_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_signed(req0_signed), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_signed(req1_signed), .req1_a(req1_a), .req1_b(req1_b),
    .mf_req(mf_req), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
    .core_start(core_start), .core_signed(core_signed), .core_a(core_a), .core_b(core_b),
    .core_busy(core_busy), .core_done(core_done), .core_product(core_product),
    .hi(hi), .lo(lo), .stall(stall)
  );

  // behavioural core: done 65 cycles after the start cycle, busy through the done cycle, no reset
  assign core_done = core_busy && cnt == 7'd1;
  always @(posedge clk) begin
    if (core_start) begin
      core_busy    <= 1'b1;
      cnt          <= 7'd65;
      core_product <= core_signed ?
        64'($signed({{32{core_a[31]}}, core_a}) * $signed({{32{core_b[31]}}, core_b})) :
        {32'b0, core_a} * {32'b0, core_b};
    end else if (core_busy) begin
      cnt <= cnt - 7'd1;
      if (cnt == 7'd1) core_busy <= 1'b0;
    end
  end

  // start pulses must never be back to back or land on a busy core
  always @(posedge clk) begin
    if (core_start) begin
      starts <= starts + 1;
      if (prev_start || core_busy) rule_bad <= rule_bad + 1;
    end
    prev_start <= core_start;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input logic exp_stall, output int cycles);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (core_done) break;
      chk({tag, "_stall"}, stall, 1);
      chk({tag, "_nostart"}, core_start, 0);
    end
    cycles = k;
    chk({tag, "_timeout"}, k < 200, 1);
    chk({tag, "_done_stall"}, stall, exp_stall);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 req0_valid = 1; req0_a = 1; req0_b = 1;
    @(negedge clk);
    chk("rst_start", core_start, 0);
    @(posedge clk);
    #1 req0_valid = 0; reset_n = 1;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall, 0);

    @(posedge clk);
    #1 req0_valid = 1; req0_signed = 1; req0_a = 32'hFFFF_FFFE; req0_b = 3; s0 = starts;
    @(negedge clk);
    chk("m1_start", core_start, 1);
    chk("m1_stall", stall, 1);
    chk("m1_a", core_a, 32'hFFFF_FFFE);
    chk("m1_sgn", core_signed, 1);
    wait_done("m1", 0, n);
    chk("m1_latency", n, 64);
    @(posedge clk);
    #1 req0_valid = 0;
    @(negedge clk);
    chk("m1_hi", hi, 32'hFFFF_FFFF);
    chk("m1_lo", lo, 32'hFFFF_FFFA);
    chk("m1_starts", starts - s0, 1);
    chk("m1_idle_stall", stall, 0);

    @(posedge clk);
    #1 req0_valid = 1; req0_signed = 0; req0_a = 32'hFFFF_FFFF; req0_b = 2;
    req1_valid = 1; req1_signed = 0; req1_a = 5; req1_b = 7; s0 = starts;
    @(negedge clk);
    chk("p0_start", core_start, 1);
    chk("p0_a", core_a, 32'hFFFF_FFFF);
    chk("p0_b", core_b, 2);
    wait_done("p0", 1, n);
    @(negedge clk);
    chk("p1_start", core_start, 1);
    chk("p1_a", core_a, 5);
    chk("p1_b", core_b, 7);
    chk("p1_stall", stall, 1);
    chk("p_mid_hi", hi, 1);
    chk("p_mid_lo", lo, 32'hFFFF_FFFE);
    wait_done("p1", 0, n);
    @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("p_hi", hi, 0);
    chk("p_lo", lo, 35);
    chk("p_starts", starts - s0, 2);

    @(posedge clk);
    #1 req0_valid = 1; req0_signed = 1; req0_a = 4; req0_b = 5; mf_req = 1;
    @(negedge clk);
    chk("mf_start", core_start, 1);
    wait_done("mf", 1, n);
    @(posedge clk);
    #1 req0_valid = 0;
    @(negedge clk);
    chk("mf_stall", stall, 0);
    chk("mf_lo", lo, 20);
    chk("mf_hi", hi, 0);
    @(posedge clk);
    #1 mf_req = 0;

    req0_valid = 1; req0_signed = 0; req0_a = 2; req0_b = 3;
    @(negedge clk);
    chk("mt_start", core_start, 1);
    @(posedge clk);
    #1 req0_valid = 0; mthi_we = 1; mt_data = 32'hDEAD;
    repeat (2) @(negedge clk);
    chk("mt_hold_hi", hi, 0);
    wait_done("mt", 0, n);
    @(posedge clk);
    #1 mthi_we = 0;
    @(negedge clk);
    chk("mt_hi", hi, 32'hDEAD);
    chk("mt_lo", lo, 6);

    @(posedge clk);
    #1 req0_valid = 1; req0_a = 3; req0_b = 3;
    @(negedge clk);
    chk("rr_start", core_start, 1);
    @(posedge clk);
    #1 req0_valid = 0;
    repeat (9) @(posedge clk);
    #1 reset_n = 0;
    @(negedge clk);
    chk("rr_rst_start", core_start, 0);
    @(posedge clk);
    #1 reset_n = 1; req0_valid = 1; req0_a = 7; req0_b = 6;
    @(negedge clk);
    chk("rr_hi", hi, 0);
    chk("rr_lo", lo, 0);
    for (n = 0; n < 200 && core_busy; n++) begin
      chk("rr_wait_stall", stall, 1);
      chk("rr_wait_nostart", core_start, 0);
      chk("rr_wait_lo", lo, 0);
      @(negedge clk);
    end
    chk("rr_timeout", n < 200, 1);
    s0 = starts;
    chk("rr_restart", core_start, 1);
    chk("rr_a", core_a, 7);
    wait_done("rr", 0, n);
    @(posedge clk);
    #1 req0_valid = 0;
    @(negedge clk);
    chk("rr_res_lo", lo, 42);
    chk("rr_res_hi", hi, 0);

    @(posedge clk);
    #1 mtlo_we = 1; mt_data = 32'h1234; mf_req = 1;
    @(negedge clk);
    chk("imt_stall", stall, 0);
    @(posedge clk);
    #1 mtlo_we = 0; mf_req = 0;
    @(negedge clk);
    chk("imt_lo", lo, 32'h1234);
    chk("imt_hi", hi, 0);
    chk("imt_stall2", stall, 0);
    chk("start_rule", rule_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
